board_link_rx: RTL



---
 rtl/link_pkg.sv | 36 +++
 rtl/link_sync_edge.sv | 33 +++
 rtl/board_link_rx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// Shared types and field helpers for the inter-board pin link.
// Used by the receiver and its synchroniser front end.
package link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    CHECK
  } link_state_t;

  localparam int DEF_SETTLE_CYC  = 49999;
  localparam int DEF_TIMEOUT_CYC = 10_000_000;

  function automatic int idx_width(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  function automatic int pay_width(
    input int pin_w,
    input int num_words,
    input int parity_en
  );
    return pin_w - 1 - idx_width(num_words) - parity_en;
  endfunction

  // Slot 0 sits in the most significant bits of a frame.
  function automatic int frame_lsb(
    input int slot,
    input int num_words,
    input int pay_w
  );
    return (num_words - 1 - slot) * pay_w;
  endfunction

endpackage

// File: rtl/link_sync_edge.sv
// Two-flop synchroniser for a pin bus with strobe on bit 0.
// Emits the synchronised data bits and a strobe rising-edge pulse.
module link_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] pins,
  output logic [W-1:1] data,
  output logic         rise
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic         strobe_d;

  // Metastability guard plus one-cycle strobe history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      strobe_d <= 1'b0;
    end else begin
      s1       <= pins;
      s2       <= s1;
      strobe_d <= s2[0];
    end
  end

  assign data = s2[W-1:1];
  assign rise = s2[0] & ~strobe_d;

endmodule

// File: rtl/board_link_rx.sv
// Receiver for the strobed inter-board pin link.
// Reassembles tagged words into frames and tracks link liveness.
module board_link_rx
  import link_pkg::*;
#(
  parameter int PIN_W       = 8,
  parameter int NUM_WORDS   = 2,
  parameter int PARITY_EN   = 0,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int IDX_W = idx_width(NUM_WORDS),
  localparam int PAY_W = pay_width(PIN_W, NUM_WORDS, PARITY_EN)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PIN_W-1:0]           link_pins,
  output logic [NUM_WORDS*PAY_W-1:0] frame_data,
  output logic                       frame_valid,
  output logic                       link_up,
  output logic                       parity_err,
  output logic                       seq_err,
  output logic [7:0]                 err_count
);

  localparam int FRAME_W = NUM_WORDS * PAY_W;
  localparam int CNT_W   = $clog2(SETTLE_CYC + 1);
  localparam int TC_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(TIMEOUT_CYC - 1);
  localparam logic [TC_W-1:0]  TC_MAX   = TC_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  link_state_t        state;
  logic [CNT_W-1:0]   cnt;
  logic [TC_W-1:0]    tcnt;
  logic [PIN_W-2:0]   pins_s;
  logic               rise;
  logic [PIN_W-2:0]   word_q;
  logic [IDX_W-1:0]   expected;
  logic [PAY_W-1:0]   shadow [NUM_WORDS];
  logic [FRAME_W-1:0] commit;

  logic [IDX_W-1:0]   w_idx;
  logic [PAY_W-1:0]   w_pay;
  logic               par_bad;
  logic               in_order;
  logic               restart;
  logic               is_last;
  logic               err_evt;
  logic               timeout_hit;

  link_sync_edge #(
    .W(PIN_W)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .pins (link_pins),
    .data (pins_s),
    .rise (rise)
  );

  assign w_idx    = word_q[PIN_W-2 -: IDX_W];
  assign w_pay    = word_q[PAY_W-1:0];
  assign par_bad  = (PARITY_EN != 0) && (^word_q);
  assign in_order = !par_bad && (w_idx == expected);
  assign restart  = !par_bad && !in_order && (w_idx == '0);
  assign is_last  = (w_idx == IDX_LAST);
  assign err_evt  = (state == CHECK) && !in_order;
  assign timeout_hit = !rise && (tcnt == TC_LAST);

  // Frame image as it would look with the current word as the last slot.
  always_comb begin
    commit = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      commit[frame_lsb(i, NUM_WORDS, PAY_W) +: PAY_W] = shadow[i];
    end
    commit[PAY_W-1:0] = w_pay;
  end

  // Cycles since the last strobe edge, held once the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (rise) begin
      tcnt <= '0;
    end else if (tcnt != TC_MAX) begin
      tcnt <= tcnt + TC_W'(1);
    end
  end

  // Word receive FSM with frame assembly, error flags and link status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      word_q      <= '0;
      expected    <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      link_up     <= 1'b0;
      parity_err  <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      seq_err     <= 1'b0;
      if (err_evt && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= SETTLE;
            cnt   <= '0;
          end
        end
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          word_q <= pins_s;
          state  <= CHECK;
        end
        CHECK: begin
          state <= IDLE;
          unique case (1'b1)
            par_bad: begin
              parity_err <= 1'b1;
              expected   <= '0;
            end
            in_order: begin
              shadow[w_idx] <= w_pay;
              if (is_last) begin
                frame_data  <= commit;
                frame_valid <= 1'b1;
                link_up     <= 1'b1;
                expected    <= '0;
              end else begin
                expected <= expected + IDX_W'(1);
              end
            end
            restart: begin
              seq_err   <= 1'b1;
              shadow[0] <= w_pay;
              expected  <= IDX_W'(1);
            end
            default: begin
              seq_err  <= 1'b1;
              expected <= '0;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
      if (timeout_hit) begin
        link_up     <= 1'b0;
        frame_data  <= '0;
        frame_valid <= 1'b0;
        expected    <= '0;
      end
    end
  end

endmodule
